// File: rtl/cla_alu_pkg.sv
// Shared widths, carry-lookahead grouping and opcode encodings for the cla_alu datapath.
package cla_alu_pkg;

    localparam int WIDTH = 18;
    localparam int GROUP = 4;
    localparam int NGRP  = (WIDTH + GROUP - 1) / GROUP;

    localparam logic [1:0] OP_ADD = 2'b00;
    localparam logic [1:0] OP_SUB = 2'b01;
    localparam logic [1:0] OP_AND = 2'b10;
    localparam logic [1:0] OP_OR  = 2'b11;

endpackage

// File: rtl/cla_alu_adder18.sv
// 18-bit two-level carry-lookahead adder built from 4-bit groups (top group is 2 bits).
// Purely combinational, zero latency, no flow control.
module cla_adder18 import cla_alu_pkg::*; (
    input  logic [WIDTH-1:0] a,
    input  logic [WIDTH-1:0] b,
    input  logic             cin,
    output logic [WIDTH-1:0] sum,
    output logic             cout
);

    logic [WIDTH-1:0] g;
    logic [WIDTH-1:0] p;
    logic [NGRP-1:0]  grp_g;
    logic [NGRP-1:0]  grp_p;
    logic [NGRP:0]    gc;

    assign g = a & b;
    assign p = a ^ b;

    for (genvar k = 0; k < NGRP; k++) begin : grp
        localparam int LO = k * GROUP;
        localparam int HI = (LO + GROUP - 1 < WIDTH) ? LO + GROUP - 1 : WIDTH - 1;
        localparam int N  = HI - LO + 1;

        logic [N-1:0] gk;
        logic [N-1:0] pk;
        logic [N-1:0] ck;
        logic         gg;
        logic         gp;

        assign gk = g[HI:LO];
        assign pk = p[HI:LO];

        // Group generate/propagate in sum-of-products form, independent of carry-in.
        always_comb begin
            gg = 1'b0;
            gp = 1'b1;
            for (int m = N - 1; m >= 0; m--) begin
                gg = gg | (gk[m] & gp);
                gp = gp & pk[m];
            end
        end

        always_comb begin
            logic acc;
            logic pp;
            ck    = '0;
            ck[0] = gc[k];
            for (int j = 1; j < N; j++) begin
                acc = 1'b0;
                pp  = 1'b1;
                for (int m = j - 1; m >= 0; m--) begin
                    acc = acc | (gk[m] & pp);
                    pp  = pp & pk[m];
                end
                ck[j] = acc | (pp & gc[k]);
            end
        end

        assign grp_g[k]  = gg;
        assign grp_p[k]  = gp;
        assign sum[HI:LO] = pk ^ ck;
    end

    // Second-level lookahead: every group carry is a flat function of cin and group G/P.
    always_comb begin
        logic acc;
        logic pp;
        gc    = '0;
        gc[0] = cin;
        for (int k = 0; k < NGRP; k++) begin
            acc = 1'b0;
            pp  = 1'b1;
            for (int m = k; m >= 0; m--) begin
                acc = acc | (grp_g[m] & pp);
                pp  = pp & grp_p[m];
            end
            gc[k+1] = acc | (pp & cin);
        end
    end

    assign cout = gc[NGRP];

endmodule

// File: rtl/cla_alu.sv
// 18-bit ADD/SUB/AND/OR ALU with signed-overflow flag; result registered, 1-cycle latency.
// No handshake: a new operation is accepted every cycle and never stalls.
module cla_alu import cla_alu_pkg::*; (
    input  logic             clk,
    input  logic             rst_n,
    input  logic [WIDTH-1:0] x,
    input  logic [WIDTH-1:0] y,
    input  logic [1:0]       s,
    output logic [WIDTH-1:0] z,
    output logic             v
);

    localparam int MSB = WIDTH - 1;

    logic             is_sub;
    logic [WIDTH-1:0] b_op;
    logic [WIDTH-1:0] sum;
    logic             carry_unused;
    logic [WIDTH-1:0] z_nxt;
    logic             v_nxt;

    // Subtraction reuses the adder as x + ~y + 1.
    assign is_sub = (s == OP_SUB);
    assign b_op   = is_sub ? ~y : y;

    cla_adder18 u_adder (
        .a    (x),
        .b    (b_op),
        .cin  (is_sub),
        .sum  (sum),
        .cout (carry_unused)
    );

    always_comb begin
        z_nxt = sum;
        v_nxt = 1'b0;
        case (s)
            OP_ADD: begin
                z_nxt = sum;
                v_nxt = (x[MSB] == y[MSB]) && (sum[MSB] != x[MSB]);
            end
            OP_SUB: begin
                z_nxt = sum;
                v_nxt = (x[MSB] != y[MSB]) && (sum[MSB] != x[MSB]);
            end
            OP_AND: z_nxt = x & y;
            OP_OR:  z_nxt = x | y;
            default: begin
                z_nxt = sum;
                v_nxt = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            z <= '0;
            v <= 1'b0;
        end else begin
            z <= z_nxt;
            v <= v_nxt;
        end
    end

endmodule

// File: tb/tb_cla_alu.sv
// Scoreboard bench for cla_alu: stimulus pushes expected z/v per clock edge, monitor pops and checks.
module tb_cla_alu;

    logic        clk;
    logic        rst_n;
    logic [17:0] x;
    logic [17:0] y;
    logic [1:0]  s;
    logic [17:0] z;
    logic        v;

    typedef struct {
        logic [17:0] z;
        logic        v;
        string       name;
    } exp_t;

    exp_t q[$];
    int   tests;
    int   fails;

    cla_alu dut (
        .clk   (clk),
        .rst_n (rst_n),
        .x     (x),
        .y     (y),
        .s     (s),
        .z     (z),
        .v     (v)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle of inputs and record what must appear after the coming rising edge.
    task automatic issue(input logic [17:0] xi, input logic [17:0] yi, input logic [1:0] si,
                         input logic rst, input logic [17:0] ez, input logic ev, input string nm);
        exp_t e;
        x     = xi;
        y     = yi;
        s     = si;
        rst_n = rst;
        e.z   = ez;
        e.v   = ev;
        e.name = nm;
        q.push_back(e);
        @(negedge clk);
    endtask

    function automatic logic [17:0] ref_z(input int a, input int b, input int op);
        int r;
        case (op)
            0:       r = a + b;
            1:       r = a - b;
            2:       r = a & b;
            default: r = a | b;
        endcase
        return r[17:0];
    endfunction

    initial begin
        exp_t e;
        forever begin
            @(posedge clk);
            #1;
            if (q.size() > 0) begin
                e = q.pop_front();
                tests++;
                if (z !== e.z || v !== e.v) begin
                    fails++;
                    $display("FAIL %s: got z=%05h v=%b, expected z=%05h v=%b", e.name, z, v, e.z, e.v);
                end
            end
        end
    end

    initial begin
        tests = 0;
        fails = 0;
        rst_n = 1'b0;
        x = '0;
        y = '0;
        s = 2'b00;
        @(negedge clk);

        issue(18'd5, 18'd3, 2'b00, 1'b0, 18'h00000, 1'b0, "reset_a");
        issue(18'd5, 18'd3, 2'b00, 1'b0, 18'h00000, 1'b0, "reset_b");
        issue(18'd5, 18'd3, 2'b00, 1'b1, 18'h00008, 1'b0, "release_add");

        issue(18'h1FFFF, 18'h00001, 2'b00, 1'b1, 18'h20000, 1'b1, "add_ovf_pos");
        issue(18'h20000, 18'h3FFFF, 2'b00, 1'b1, 18'h1FFFF, 1'b1, "add_ovf_neg");
        issue(18'h3FFFF, 18'h3FFFF, 2'b00, 1'b1, 18'h3FFFE, 1'b0, "add_neg_noovf");
        issue(18'h20000, 18'h00001, 2'b01, 1'b1, 18'h1FFFF, 1'b1, "sub_ovf_neg");
        issue(18'h1FFFF, 18'h3FFFF, 2'b01, 1'b1, 18'h20000, 1'b1, "sub_ovf_pos");
        issue(18'h00000, 18'd999,   2'b01, 1'b1, 18'h3FC19, 1'b0, "sub_0_999");
        issue(18'h3FC19, 18'h3FC19, 2'b01, 1'b1, 18'h00000, 1'b0, "sub_self");
        issue(18'h2AAAA, 18'h0FFFF, 2'b10, 1'b1, 18'h0AAAA, 1'b0, "and");
        issue(18'h2AAAA, 18'h0FFFF, 2'b11, 1'b1, 18'h2FFFF, 1'b0, "or");
        issue(18'h2AAAA, 18'h0FFFF, 2'b00, 1'b1, 18'h3AAA9, 1'b0, "s_only_add");
        issue(18'h1FFFF, 18'h00001, 2'b10, 1'b1, 18'h00001, 1'b0, "and_no_ovf");
        issue(18'h1FFFF, 18'h00001, 2'b11, 1'b1, 18'h1FFFF, 1'b0, "or_no_ovf");

        // Magnitudes up to 999 in every sign quadrant can never overflow 18 bits.
        for (int xi = -999; xi <= 999; xi += 111) begin
            for (int yi = -999; yi <= 999; yi += 137) begin
                for (int op = 0; op < 4; op++) begin
                    issue(18'(xi), 18'(yi), 2'(op), 1'b1, ref_z(xi, yi, op), 1'b0, "sweep");
                end
            end
        end

        issue(18'd100, 18'd200, 2'b00, 1'b0, 18'h00000, 1'b0, "midstream_reset");
        issue(18'd7, 18'h3FFFD, 2'b00, 1'b1, 18'h00004, 1'b0, "after_reset");
        issue(18'd7, 18'd3, 2'b01, 1'b1, 18'h00004, 1'b0, "after_reset_sub");

        @(negedge clk);
        @(negedge clk);
        if (q.size() != 0) begin
            tests++;
            fails++;
            $display("FAIL drain: %0d expectations left unchecked, required 0", q.size());
        end
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
